// File: rtl/ddr3_app_arbiter.sv
// DDR3 app-port arbiter: one write and one read requester share the
// controller, one burst in flight, alternating on contention.
module ddr3_app_arbiter #(
   parameter int ADDR_WIDTH  = 28,
   parameter int BURST_WIDTH = 6,
   parameter int CMD_WIDTH   = 3
) (
   input  logic                   I_dma_clk,
   input  logic                   I_rst_n,
   input  logic                   I_init_calib_complete,
   input  logic                   I_wr_req,
   input  logic [ADDR_WIDTH-1:0]  I_wr_addr,
   input  logic [BURST_WIDTH-1:0] I_wr_burst,
   output logic                   O_wr_gnt,
   output logic                   O_wr_pull,
   output logic                   O_wr_done,
   input  logic                   I_rd_req,
   input  logic [ADDR_WIDTH-1:0]  I_rd_addr,
   input  logic [BURST_WIDTH-1:0] I_rd_burst,
   output logic                   O_rd_gnt,
   output logic                   O_rd_valid,
   output logic                   O_rd_done,
   input  logic                   I_cmd_ready,
   output logic [CMD_WIDTH-1:0]   O_cmd,
   output logic                   O_cmd_en,
   output logic [ADDR_WIDTH-1:0]  O_addr,
   output logic [BURST_WIDTH-1:0] O_app_burst_number,
   input  logic                   I_wr_data_rdy,
   output logic                   O_wr_data_en,
   output logic                   O_wr_data_end,
   input  logic                   I_rd_data_valid
);

   typedef enum logic [2:0] {
      IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA
   } state_t;

   state_t                 state_q, state_d;
   logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
   logic [BURST_WIDTH-1:0] burst_q, burst_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
   logic                   last_rd_q, last_rd_d;
   logic                   wr_gnt_q, wr_gnt_d;
   logic                   rd_gnt_q, rd_gnt_d;
   logic                   wr_done_q, wr_done_d;
   logic                   rd_done_q, rd_done_d;
   logic                   cmd_en, wr_en, wr_end, rd_vld;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      burst_d   = burst_q;
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      last_rd_d = last_rd_q;
      wr_gnt_d  = 1'b0;
      rd_gnt_d  = 1'b0;
      wr_done_d = 1'b0;
      rd_done_d = 1'b0;
      cmd_en    = 1'b0;
      wr_en     = 1'b0;
      wr_end    = 1'b0;
      rd_vld    = 1'b0;
      // Losing calibration abandons the burst silently
      if (!I_init_calib_complete) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (I_wr_req && (!I_rd_req || last_rd_q)) begin
                  state_d  = WR_CMD;
                  addr_d   = I_wr_addr;
                  burst_d  = I_wr_burst;
                  cmd_d    = '0;
                  wr_gnt_d = 1'b1;
               end else if (I_rd_req) begin
                  state_d  = RD_CMD;
                  addr_d   = I_rd_addr;
                  burst_d  = I_rd_burst;
                  cmd_d    = CMD_WIDTH'(1);
                  rd_gnt_d = 1'b1;
               end
            end
            WR_CMD: begin
               cmd_en = I_cmd_ready;
               cnt_d  = '0;
               if (I_cmd_ready) state_d = WR_DATA;
            end
            RD_CMD: begin
               cmd_en = I_cmd_ready;
               cnt_d  = '0;
               if (I_cmd_ready) state_d = RD_DATA;
            end
            WR_DATA: begin
               wr_en  = I_wr_data_rdy;
               wr_end = wr_en && (cnt_q == burst_q);
               if (wr_end) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  wr_done_d = 1'b1;
                  last_rd_d = 1'b0;
               end else if (wr_en) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            RD_DATA: begin
               rd_vld = I_rd_data_valid;
               if (rd_vld && (cnt_q == burst_q)) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  rd_done_d = 1'b1;
                  last_rd_d = 1'b1;
               end else if (rd_vld) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         burst_q   <= '0;
         addr_q    <= '0;
         cmd_q     <= '0;
         last_rd_q <= 1'b1;
         wr_gnt_q  <= 1'b0;
         rd_gnt_q  <= 1'b0;
         wr_done_q <= 1'b0;
         rd_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         burst_q   <= burst_d;
         addr_q    <= addr_d;
         cmd_q     <= cmd_d;
         last_rd_q <= last_rd_d;
         wr_gnt_q  <= wr_gnt_d;
         rd_gnt_q  <= rd_gnt_d;
         wr_done_q <= wr_done_d;
         rd_done_q <= rd_done_d;
      end
   end

   assign O_wr_gnt           = wr_gnt_q;
   assign O_rd_gnt           = rd_gnt_q;
   assign O_wr_done          = wr_done_q;
   assign O_rd_done          = rd_done_q;
   assign O_cmd              = cmd_q;
   assign O_addr             = addr_q;
   assign O_app_burst_number = burst_q;
   assign O_cmd_en           = cmd_en;
   assign O_wr_data_en       = wr_en;
   assign O_wr_pull          = wr_en;
   assign O_wr_data_end      = wr_end;
   assign O_rd_valid         = rd_vld;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Bench for ddr3_app_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_ddr3_app_arbiter;
   localparam int AW = 28;
   localparam int BW = 6;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          calib = 1'b0;
   logic          wr_req = 1'b0, rd_req = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [BW-1:0] wr_burst = '0, rd_burst = '0;
   logic          cmd_ready = 1'b0, wdrdy = 1'b0, rdv = 1'b0;

   logic          wr_gnt, wr_pull, wr_done, rd_gnt, rd_valid, rd_done;
   logic [CW-1:0] cmd;
   logic          cmd_en, wen, wend;
   logic [AW-1:0] addr;
   logic [BW-1:0] burst;

   ddr3_app_arbiter #(.ADDR_WIDTH(AW), .BURST_WIDTH(BW), .CMD_WIDTH(CW)) dut (
      .I_dma_clk(clk), .I_rst_n(rst_n), .I_init_calib_complete(calib),
      .I_wr_req(wr_req), .I_wr_addr(wr_addr), .I_wr_burst(wr_burst),
      .O_wr_gnt(wr_gnt), .O_wr_pull(wr_pull), .O_wr_done(wr_done),
      .I_rd_req(rd_req), .I_rd_addr(rd_addr), .I_rd_burst(rd_burst),
      .O_rd_gnt(rd_gnt), .O_rd_valid(rd_valid), .O_rd_done(rd_done),
      .I_cmd_ready(cmd_ready), .O_cmd(cmd), .O_cmd_en(cmd_en),
      .O_addr(addr), .O_app_burst_number(burst),
      .I_wr_data_rdy(wdrdy), .O_wr_data_en(wen), .O_wr_data_end(wend),
      .I_rd_data_valid(rdv)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   wire [63:0] act_vec = {18'd0, wr_gnt, wr_pull, wr_done, rd_gnt,
                          rd_valid, rd_done, cmd, cmd_en, addr, burst,
                          wen, wend};

   // Transaction model: which burst is open, whether its command is
   // still pending, and how many beats of burst+1 have moved.
   int          m_busy;  // 0 none, 1 write, 2 read
   bit          m_pend;
   int          m_beats, m_total;
   bit [AW-1:0] m_addr;
   bit [BW-1:0] m_burst;
   bit [CW-1:0] m_cmd;
   bit          m_wg, m_rg, m_wd, m_rd, m_last_rd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_pend = 0; m_beats = 0; m_total = 0;
         m_addr = '0; m_burst = '0; m_cmd = '0;
         m_wg = 0; m_rg = 0; m_wd = 0; m_rd = 0; m_last_rd = 1;
      end else begin
         m_wg = 0; m_rg = 0; m_wd = 0; m_rd = 0;
         if (!calib) begin
            m_busy = 0; m_pend = 0; m_beats = 0;
         end else if (m_busy == 0) begin
            if (wr_req && (!rd_req || m_last_rd)) begin
               m_busy = 1; m_addr = wr_addr; m_burst = wr_burst;
               m_cmd = 0; m_wg = 1;
            end else if (rd_req) begin
               m_busy = 2; m_addr = rd_addr; m_burst = rd_burst;
               m_cmd = 1; m_rg = 1;
            end
            if (m_busy != 0) begin
               m_pend = 1; m_beats = 0; m_total = int'(m_burst) + 1;
            end
         end else if (m_pend) begin
            if (cmd_ready) m_pend = 0;
         end else if ((m_busy == 1 && wdrdy) || (m_busy == 2 && rdv)) begin
            m_beats++;
            if (m_beats == m_total) begin
               if (m_busy == 1) m_wd = 1; else m_rd = 1;
               m_last_rd = (m_busy == 2);
               m_busy = 0;
            end
         end
      end
   end

   // Observation counters for the directed scenarios
   int n_wgnt, n_rgnt, n_wen, n_wend, wend_at, n_wdone, n_rdone;
   int n_rvalid, n_cmd_en, n_overlap, outst;
   logic [AW-1:0] last_cmd_addr;
   logic [CW-1:0] last_cmd;
   bit gq[$];

   task automatic clear_obs();
      n_wgnt = 0; n_rgnt = 0; n_wen = 0; n_wend = 0; wend_at = 0;
      n_wdone = 0; n_rdone = 0; n_rvalid = 0; n_cmd_en = 0;
      n_overlap = 0; outst = 0; last_cmd_addr = '0; last_cmd = '0;
      gq.delete();
   endtask

   always @(negedge clk) begin
      logic e_cmd_en, e_wen, e_wend, e_rv;
      logic [63:0] exp_vec;
      e_cmd_en = calib && m_busy != 0 && m_pend && cmd_ready;
      e_wen    = calib && m_busy == 1 && !m_pend && wdrdy;
      e_wend   = e_wen && (m_beats == m_total - 1);
      e_rv     = calib && m_busy == 2 && !m_pend && rdv;
      exp_vec  = {18'd0, m_wg, e_wen, m_wd, m_rg, e_rv, m_rd, m_cmd,
                  e_cmd_en, m_addr, m_burst, e_wen, e_wend};
      chk("model_outputs", act_vec, exp_vec);
      if (wr_gnt) begin
         n_wgnt++; gq.push_back(1'b0);
         if (outst != 0) n_overlap++;
         outst++;
      end
      if (rd_gnt) begin
         n_rgnt++; gq.push_back(1'b1);
         if (outst != 0) n_overlap++;
         outst++;
      end
      if (wr_done) begin n_wdone++; outst--; end
      if (rd_done) begin n_rdone++; outst--; end
      if (rd_valid) n_rvalid++;
      if (wen) n_wen++;
      if (wend) begin n_wend++; wend_at = n_wen; end
      if (cmd_en) begin
         n_cmd_en++; last_cmd_addr = addr; last_cmd = cmd;
      end
   end

   initial begin
      clear_obs();
      #2;
      chk("reset_outputs", act_vec, 64'd0);
      step(); step();
      rst_n = 1'b1;
      calib = 1'b1;
      step();

      // Single write, burst 3
      clear_obs();
      wr_addr = 28'h0000400; wr_burst = 6'd3;
      cmd_ready = 1'b1; wdrdy = 1'b1; wr_req = 1'b1;
      step();
      wr_req = 1'b0;
      repeat (10) step();
      chk("wr_gnt_count", n_wgnt, 1);
      chk("wr_cmd_en_count", n_cmd_en, 1);
      chk("wr_cmd_addr", last_cmd_addr, 28'h0000400);
      chk("wr_cmd_val", last_cmd, 0);
      chk("wr_beats", n_wen, 4);
      chk("wr_end_count", n_wend, 1);
      chk("wr_end_beat", wend_at, 4);
      chk("wr_done_count", n_wdone, 1);

      // Read, burst 0, with spurious valids outside the burst
      clear_obs();
      wdrdy = 1'b0; rdv = 1'b1;
      step();
      rdv = 1'b0;
      chk("spurious_rvalid", n_rvalid, 0);
      rd_addr = 28'h0000123; rd_burst = 6'd0; rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      step();
      rdv = 1'b1;
      step();
      rdv = 1'b0;
      repeat (4) step();
      rdv = 1'b1;
      repeat (2) step();
      rdv = 1'b0;
      chk("rd_gnt_count", n_rgnt, 1);
      chk("rd_cmd_val", last_cmd, 1);
      chk("rd_cmd_addr", last_cmd_addr, 28'h0000123);
      chk("rd_valid_count", n_rvalid, 1);
      chk("rd_done_count", n_rdone, 1);

      // Tie: both held, grants must alternate starting with write
      clear_obs();
      wr_addr = 28'h0000800; rd_addr = 28'h0000900;
      wr_burst = 6'd1; rd_burst = 6'd1;
      wdrdy = 1'b1; rdv = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      repeat (40) step();
      wr_req = 1'b0; rd_req = 1'b0;
      repeat (12) step();
      rdv = 1'b0; wdrdy = 1'b0;
      chk("tie_enough_grants", gq.size() >= 4, 1);
      foreach (gq[i]) chk($sformatf("tie_order_%0d", i), gq[i], i % 2);
      chk("tie_overlap", n_overlap, 0);

      // Backpressure on command and write data
      clear_obs();
      cmd_ready = 1'b0; wdrdy = 1'b0;
      wr_addr = 28'h0000ABC; wr_burst = 6'd3; wr_req = 1'b1;
      step();
      wr_req = 1'b0; wr_addr = 28'h0000555;
      repeat (10) begin
         @(negedge clk);
         chk("stall_addr", addr, 28'h0000ABC);
         chk("stall_cmd_en", cmd_en, 0);
         step();
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wdrdy = (i % 2 == 0);
         step();
      end
      wdrdy = 1'b0;
      repeat (3) step();
      chk("bp_cmd_en_count", n_cmd_en, 1);
      chk("bp_beats", n_wen, 4);
      chk("bp_end_count", n_wend, 1);
      chk("bp_end_beat", wend_at, 4);
      chk("bp_done", n_wdone, 1);

      // Calibration loss after 2 of 8 beats
      clear_obs();
      wdrdy = 1'b1;
      wr_addr = 28'h0001000; wr_burst = 6'd7; wr_req = 1'b1;
      step();
      wr_req = 1'b0;
      repeat (3) step();
      calib = 1'b0;
      #1;
      chk("calib_wen_immediate", wen, 0);
      wr_req = 1'b1;
      repeat (6) step();
      chk("calib_beats", n_wen, 2);
      chk("calib_no_done", n_wdone, 0);
      chk("calib_no_grant", n_wgnt, 1);
      calib = 1'b1;
      step();
      wr_req = 1'b0;
      repeat (15) step();
      chk("calib_regrant", n_wgnt, 2);
      chk("calib_rerun_beats", n_wen, 10);
      chk("calib_rerun_done", n_wdone, 1);

      // Async reset mid read burst
      clear_obs();
      wdrdy = 1'b0;
      rd_addr = 28'h0002000; rd_burst = 6'd7; rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      step();
      rdv = 1'b1;
      step(); step();
      rst_n = 1'b0;
      #1;
      chk("reset_mid_burst", act_vec, 64'd0);
      gq.delete();
      wr_req = 1'b1; rd_req = 1'b1;
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("release_no_gnt", wr_gnt | rd_gnt, 0);
      step(); step();
      wr_req = 1'b0; rd_req = 1'b0; rdv = 1'b0;
      repeat (6) step();
      chk("reset_no_rd_done", n_rdone, 0);
      chk("reset_grant_seen", gq.size() >= 1, 1);
      if (gq.size() >= 1) chk("reset_first_is_write", gq[0], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
